// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: widths, reset PC, fetch-state
// encoding and opcode constants used by fetch, decode and the benches.
package cpu_pkg;

  localparam int unsigned PC_W     = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned RESET_PC = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SW   = 4'b0110;
  localparam logic [3:0] BEQ  = 4'b0111;
  localparam logic [3:0] ADDI = 4'b1001;
  localparam logic [3:0] J    = 4'b1111;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the external combinational
// ROM, registers each word into the IF/ID stage and handles redirect/halt.
module fetch_ctrl #(
  parameter int unsigned PC_W     = cpu_pkg::PC_W,
  parameter int unsigned INSTR_W  = cpu_pkg::INSTR_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign accept = valid_q & id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = accept ? cnt_q + CNT_W'(1) : cnt_q;

    unique case (state_q)
      RUN: begin
        // Redirect beats halt; a squashed word taken this cycle is still counted above.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (halt_req) begin
          if (valid_q && !accept) begin
            state_d = DRAIN;
          end else begin
            state_d = HALTED;
            valid_d = 1'b0;
          end
        end else if (!valid_q || id_ready) begin
          instr_d = imem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      DRAIN: begin
        if (accept) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = HALTED;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= PC_W'(RESET_PC);
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus drives a stream-level reference
// model and queues expected outputs; a monitor pops and compares each cycle.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] rom [256];
  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .halted(halted), .fetch_count(fetch_count)
  );

  typedef struct {
    bit          valid;
    bit          chk_data;
    int unsigned ipc;
    int unsigned instr;
    int unsigned addr;
    bit          halted;
    int unsigned cnt;
  } exp_t;

  exp_t sb_q[$];
  int unsigned tests = 0;
  int unsigned failed = 0;

  // Reference model: mode 0 = fetching, 1 = draining, 2 = stopped
  int unsigned m_pc, m_ipc, m_instr, m_cnt, m_mode;
  bit          m_valid;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rv,
                       input int unsigned rpc, input bit hr);
    exp_t e;
    bit   took;
    @(negedge clk);
    rst = r; id_ready = rdy; redirect_valid = rv;
    redirect_pc = 8'(rpc); halt_req = hr;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_cnt = 0; m_mode = 0;
    end else begin
      took = m_valid && rdy;
      if (took) m_cnt = (m_cnt + 1) % 65536;
      if (m_mode == 0) begin
        if (rv) begin
          m_pc = rpc % 256;
          m_valid = 0;
        end else if (hr) begin
          if (m_valid && !took) m_mode = 1;
          else begin m_mode = 2; m_valid = 0; end
        end else if (!m_valid || rdy) begin
          m_ipc = m_pc;
          m_instr = rom[m_pc];
          m_valid = 1;
          m_pc = (m_pc + 1) % 256;
        end
      end else if (m_mode == 1) begin
        if (took) begin m_mode = 2; m_valid = 0; end
      end
    end
    e.valid = m_valid; e.chk_data = r || m_valid;
    e.ipc = m_ipc; e.instr = m_instr; e.addr = m_pc;
    e.halted = (m_mode == 2); e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("if_valid", 32'(if_valid), 32'(e.valid));
        check("imem_addr", 32'(imem_addr), e.addr);
        check("halted", 32'(halted), 32'(e.halted));
        check("fetch_count", 32'(fetch_count), e.cnt);
        if (e.chk_data) begin
          check("if_pc", 32'(if_pc), e.ipc);
          check("if_instr", 32'(if_instr), e.instr);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned idle;
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt_req = 1'b0;
    for (int unsigned i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h9011; rom[1] = 16'h9021; rom[2] = 16'h9035;
    rom[4] = 16'h7355; rom[9] = 16'hF004;

    // Reset and straight-line fetch
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    // Stall on pc 4, then release
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Run up to pc 9, redirect back to 4
    for (int i = 0; i < 20 && !(m_valid && m_ipc == 9); i++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 4, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // PC wrap 255 -> 0
    drive(0, 1, 1, 254, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
    // Halt while stalled: drain, then stop; redirects ignored
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 77, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 20, 0);
    drive(0, 1, 1, 40, 1);
    // Reset during drain, then during a redirect
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
    drive(1, 1, 1, 30, 0);
    // Halt with word accepted in the same cycle
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Randomised traffic
    idle = 0;
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = ($urandom_range(0, 199) == 0) || (idle > 4);
      drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 255), $urandom_range(0, 59) == 0);
      idle = (m_mode == 2) ? idle + 1 : 0;
    end
    drive(0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 16-bit RISC core. It owns the program counter and drives the address of the combinational instruction ROM (256 x 16, `instr_mem`). It captures each returned word into an IF/ID output register and hands it to decode over a valid/ready handshake. It also applies branch/jump redirects from execute and halt requests, and keeps a retired-fetch counter for debug.

Parameters:
PC_W, 8, program-counter / ROM address width
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of fetch_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_addr  out  PC_W  address to instruction ROM (= pc register, no combinational path from inputs)
imem_data  in  INSTR_W  instruction word from ROM, combinational in imem_addr
if_instr  out  INSTR_W  registered instruction to decode
if_pc  out  PC_W  address of if_instr
if_valid  out  1  if_instr/if_pc hold a live instruction
id_ready  in  1  decode accepts if_instr this cycle
redirect_valid  in  1  branch taken / jump from execute, single-cycle pulse
redirect_pc  in  PC_W  target address
halt_req  in  1  stop fetching (sampled, sticky until reset)
halted  out  1  fetch stopped and output register drained
fetch_count  out  CNT_W  number of instructions accepted by decode

Behaviour:
- All state updates occur on rising clk. rst has top priority.
- Reset values: pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, fetch_count=0, state=RUN.
- States: RUN (fetching), DRAIN (halt seen, waiting for last word to be taken), HALTED.
- accept = if_valid & id_ready. fetch_count increments on accept and wraps at 2^CNT_W.
- load_en = (state==RUN) & ~redirect_valid & ~halt_req & (~if_valid | id_ready).
- On load_en: if_instr<=imem_data, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2^PC_W; 255 wraps to 0).
- Latency: the first valid instruction appears one cycle after rst deasserts. In steady state with id_ready=1, throughput is one instruction per cycle.
- Stall: if_valid=1 and id_ready=0 leaves if_instr, if_pc, if_valid and pc all unchanged.
- Redirect (state RUN):
  - pc<=redirect_pc and if_valid<=0, squashing the wrong-path word whether or not id_ready is high that cycle.
  - A squashed word with id_ready=1 still counts as accepted (decode consumed it), so fetch_count increments.
  - The target word appears on if_instr the following cycle.
  - Redirect wins over halt_req in the same cycle; halt takes effect the next cycle if it is still asserted.
- Halt: halt_req in RUN goes to DRAIN if if_valid & ~accept, otherwise directly to HALTED with if_valid<=0. No new fetch occurs in the halt cycle.
- DRAIN goes to HALTED on accept, clearing if_valid.
- HALTED asserts halted=1 and pc freezes. Redirect and halt_req are ignored in DRAIN/HALTED. Only rst leaves HALTED.
- Reset mid-operation (any state, any handshake phase) returns to reset values next edge; no partially captured word survives.

Decomposition:
- Shared package `cpu_pkg`: PC_W, INSTR_W, RESET_PC, the fetch-state enum (RUN/DRAIN/HALTED), and opcode constants (ADDI=4'b1001, BEQ=4'b0111, J=4'b1111, SW=4'b0110, ADD=4'b0000) for the bench and decode.
- No sub-module. The ROM stays external, instantiated beside fetch_ctrl in the core top.

Test Plan:
1. Reset, then id_ready=1 with the standard program (rom[0]=0x9011, rom[1]=0x9021, rom[2]=0x9035) -> cycle 1: if_valid=1, if_pc=0, if_instr=0x9011; cycle 2: if_pc=1, 0x9021; cycle 3: if_pc=2, 0x9035; fetch_count counts 1,2,3.
2. id_ready=0 for 3 cycles while if_pc=4 (0x7355) -> if_instr, if_pc and imem_addr=5 hold; release -> if_pc=5 next cycle; fetch_count increments only once for pc 4.
3. redirect_valid with redirect_pc=4 while if_pc=9 (0xF004) and id_ready=1 -> next cycle if_valid=0, imem_addr=4; following cycle if_pc=4, if_instr=0x7355.
4. pc at 255 with id_ready=1 -> if_pc=255, then if_pc=0 (wrap), no stall cycle.
5. halt_req while if_valid=1 and id_ready=0 -> state DRAIN, halted=0, pc frozen; assert id_ready -> halted=1 next cycle, if_valid=0; a later redirect_valid leaves pc unchanged.
6. rst asserted during DRAIN and again during a redirect cycle -> next edge: if_valid=0, halted=0, fetch_count=0, imem_addr=0.
